// File: rtl/gpio_mmio_ctrl.sv
// Memory-mapped parallel I/O controller: N_PORTS ports of OUT/DIR/IN/FLAG registers
// on the data-memory bus, with per-bit direction, input synchroniser and edge flags.

module gpio_port #(
    parameter int DATA_W    = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_out_i,
    input  logic              wr_dir_i,
    input  logic              wr_flag_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] pin_i,
    output logic [DATA_W-1:0] out_o,
    output logic [DATA_W-1:0] dir_o,
    output logic [DATA_W-1:0] in_o,
    output logic [DATA_W-1:0] flag_o
);
    logic [DATA_W-1:0] out_q, out_d, dir_q, dir_d, flag_q, flag_d;
    logic [DATA_W-1:0] sync1_q, sync2_q, prev_q;
    logic [DATA_W-1:0] evt;

    always_comb begin
        if (EDGE_MODE == 0)      evt = sync2_q & ~prev_q;
        else if (EDGE_MODE == 1) evt = ~sync2_q & prev_q;
        else                     evt = sync2_q ^ prev_q;
        // Output bits never flag; set is OR'd after the clear so it wins.
        evt    = evt & ~dir_q;
        out_d  = wr_out_i ? wdata_i : out_q;
        dir_d  = wr_dir_i ? wdata_i : dir_q;
        flag_d = (flag_q & ~(wr_flag_i ? wdata_i : '0)) | evt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            dir_q   <= '0;
            flag_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            flag_q  <= flag_d;
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign out_o  = out_q;
    assign dir_o  = dir_q;
    assign in_o   = (dir_q & out_q) | (~dir_q & sync2_q);
    assign flag_o = flag_q;
endmodule

module gpio_mmio_ctrl #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                N_PORTS   = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hE0,
    parameter int                EDGE_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      we,
    output logic [DATA_W-1:0]         rdata,
    output logic                      hit,
    input  logic [N_PORTS*DATA_W-1:0] pin_in,
    output logic [N_PORTS*DATA_W-1:0] pin_out,
    output logic [N_PORTS*DATA_W-1:0] pin_oe,
    output logic                      irq
);
    localparam logic [ADDR_W:0] WIN = (ADDR_W+1)'(4*N_PORTS);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-3:0] pidx;
    logic [1:0]        rsel;
    logic [N_PORTS-1:0][DATA_W-1:0] out_w, dir_w, in_w, flag_w;

    assign off  = addr - BASE_ADDR;
    assign hit  = (addr >= BASE_ADDR) && ({1'b0, off} < WIN);
    assign pidx = off[ADDR_W-1:2];
    assign rsel = off[1:0];

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic wsel;
        assign wsel = we && hit && (pidx == (ADDR_W-2)'(p));

        gpio_port #(.DATA_W(DATA_W), .EDGE_MODE(EDGE_MODE)) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_out_i (wsel && rsel == 2'd0),
            .wr_dir_i (wsel && rsel == 2'd1),
            .wr_flag_i(wsel && rsel == 2'd3),
            .wdata_i  (wdata),
            .pin_i    (pin_in[p*DATA_W +: DATA_W]),
            .out_o    (out_w[p]),
            .dir_o    (dir_w[p]),
            .in_o     (in_w[p]),
            .flag_o   (flag_w[p])
        );
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (pidx == (ADDR_W-2)'(p)) begin
                    case (rsel)
                        2'd0:    rdata = out_w[p];
                        2'd1:    rdata = dir_w[p];
                        2'd2:    rdata = in_w[p];
                        default: rdata = flag_w[p];
                    endcase
                end
            end
        end
    end

    assign pin_out = out_w;
    assign pin_oe  = dir_w;
    assign irq     = |flag_w;
endmodule
